// File: rtl/squeeze_stream.sv
// Purpose: SHAKE128 squeeze side; streams the rate block out as W-bit words, requesting permutations as needed.
// Latency: first word one cycle after start (or after perm_done); one word per cycle under continuous ready.
// Backpressure: out_data/out_valid hold while out_ready=0; a stalled consumer simply stretches STREAM.
module squeeze_stream #(
  parameter int R  = 1344,
  parameter int W  = 64,
  parameter int LW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] req_words,
  input  logic [R-1:0]  rate_in,
  output logic          perm_start,
  input  logic          perm_done,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int NW = R / W;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_REQ,
    S_WAIT,
    S_FIN
  } state_t;

  state_t state, state_nxt;

  // Rate block viewed as NW little-endian words; word 0 sits in the low bits.
  logic [NW-1:0][W-1:0] buffer;
  logic [IW-1:0]        idx;
  logic [LW-1:0]        rem;

  logic load_first;  // start accepted with a non-zero count
  logic load_block;  // fresh rate block arriving from the permutation
  logic xfer;        // word handed to the consumer this edge

  // State register; reset abandons any squeeze in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. Outputs come straight from state so that
  // an asserted reset drops them without waiting for a clock edge.
  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    load_block = 1'b0;
    xfer       = 1'b0;
    out_valid  = 1'b0;
    perm_start = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    out_data   = buffer[idx];
    case (state)
      S_IDLE: begin
        if (start) begin
          if (req_words != '0) begin
            load_first = 1'b1;
            state_nxt  = S_STREAM;
          end else begin
            state_nxt = S_FIN;
          end
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          xfer = 1'b1;
          // Final word wins over a block boundary: no permutation is wasted.
          if (rem == LW'(1)) begin
            state_nxt = S_FIN;
          end else if (idx == IDX_LAST) begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        perm_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (perm_done) begin
          load_block = 1'b1;
          state_nxt  = S_STREAM;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: buffer capture, word index and remaining-word count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer <= '0;
      idx    <= '0;
      rem    <= '0;
    end else if (load_first) begin
      buffer <= rate_in;
      idx    <= '0;
      rem    <= req_words;
    end else if (load_block) begin
      // idx already wrapped to 0 on the last word of the previous block.
      buffer <= rate_in;
    end else if (xfer) begin
      rem <= rem - LW'(1);
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_squeeze_stream.sv
// Purpose: self-checking bench for squeeze_stream with a word scoreboard and a permutation responder.
// Latency: expects first word one cycle after start and done one cycle after the last transfer.
// Backpressure: drives out_ready always-on, 1-0-0 patterned and random; checks data holds while stalled.
module tb_squeeze_stream;

  localparam int R        = 1344;
  localparam int W        = 64;
  localparam int LW       = 16;
  localparam int NW       = R / W;
  localparam int PERM_LAT = 24;
  localparam int BUDGET   = 2000;

  logic          clk;
  logic          rst;
  logic          start;
  logic [LW-1:0] req_words;
  logic [R-1:0]  rate_in;
  logic          perm_start;
  logic          perm_done;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int rate_blk;
  int n_checks;
  int n_fail;

  logic [63:0] exp_q[$];

  typedef struct {
    int req;
    int mode;      // 0: ready always, 1: ready 1,0,0 repeating, 2: random ready
    int exp_perm;
    bit spurious;  // extra start pulse while busy
  } vec_t;

  vec_t vecs[8];

  squeeze_stream #(.R(R), .W(W), .LW(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req_words  (req_words),
    .rate_in    (rate_in),
    .perm_start (perm_start),
    .perm_done  (perm_done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Block b carries word k = b*0xA0 + k, so block 0 is 0..20 and block 1 is A0..B4.
  always_comb begin
    rate_in = '0;
    for (int k = 0; k < NW; k++) begin
      rate_in[k*W +: W] = 64'(rate_blk) * 64'hA0 + 64'(k);
    end
  end

  function automatic logic [63:0] exp_word(input int base, input int j);
    int blk;
    blk = base + j / NW;
    return 64'(blk) * 64'hA0 + 64'(j % NW);
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return (cyc % 3) == 0;
    if (mode == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic record_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Drive one squeeze and score every word, permutation request and done pulse.
  task automatic run_squeeze(input int req, input int mode, input int exp_perm,
                             input bit spurious, input int base);
    int cyc, xfers, perms, countdown, first_v, last_x, done_at;
    logic [63:0] hold_dat;
    bit hold, finished, valid_seen;
    cyc = 0; xfers = 0; perms = 0; countdown = 0;
    first_v = -1; last_x = -1; done_at = -1;
    hold = 1'b0; hold_dat = '0; finished = 1'b0; valid_seen = 1'b0;
    exp_q.delete();
    for (int j = 0; j < req; j++) exp_q.push_back(exp_word(base, j));
    @(posedge clk); #1;
    rate_blk  = base;
    start     = 1'b1;
    req_words = LW'(req);
    perm_done = 1'b0;
    out_ready = ready_for(mode, 0);
    while (!finished && cyc < BUDGET) begin
      @(negedge clk);
      if (hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, hold_dat);
      end
      hold     = out_valid && !out_ready;
      hold_dat = out_data;
      if (out_valid) begin
        valid_seen = 1'b1;
        if (first_v < 0) first_v = cyc;
      end
      if (out_valid && out_ready) begin
        xfers++;
        last_x = cyc;
        if (exp_q.size() == 0) record_fail("extra_word");
        else check("word", out_data, exp_q.pop_front());
      end
      if (perm_start) begin
        perms++;
        countdown = PERM_LAT;
      end
      if (done) begin
        done_at  = cyc;
        finished = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      start     = 1'b0;
      perm_done = 1'b0;
      if (spurious && cyc == 3) begin
        start     = 1'b1;
        req_words = LW'(5);
      end
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          rate_blk++;
          perm_done = 1'b1;
        end
      end
      out_ready = ready_for(mode, cyc);
    end
    if (!finished) record_fail("timeout_waiting_done");
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_after", 64'(busy), 64'd0);
    check("xfer_count", 64'(xfers), 64'(req));
    check("perm_count", 64'(perms), 64'(exp_perm));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    if (req > 0) begin
      check("first_latency", 64'(first_v), 64'd1);
      check("done_latency", 64'(done_at), 64'(last_x + 1));
    end else begin
      check("done_latency_zero", 64'(done_at), 64'd1);
      check("valid_never", 64'(valid_seen), 64'd0);
    end
  endtask

  initial begin
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    req_words = '0;
    rate_blk  = 0;
    perm_done = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{req: 3,  mode: 0, exp_perm: 0, spurious: 1'b0};
    vecs[1] = '{req: 21, mode: 0, exp_perm: 0, spurious: 1'b0};
    vecs[2] = '{req: 23, mode: 0, exp_perm: 1, spurious: 1'b0};
    vecs[3] = '{req: 5,  mode: 1, exp_perm: 0, spurious: 1'b0};
    vecs[4] = '{req: 0,  mode: 0, exp_perm: 0, spurious: 1'b0};
    vecs[5] = '{req: 10, mode: 0, exp_perm: 0, spurious: 1'b1};
    vecs[6] = '{req: 42, mode: 0, exp_perm: 1, spurious: 1'b0};
    vecs[7] = '{req: 50, mode: 2, exp_perm: 2, spurious: 1'b0};

    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_perm_start", 64'(perm_start), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_squeeze(vecs[v].req, vecs[v].mode, vecs[v].exp_perm, vecs[v].spurious, 0);
    end

    // Reset in the middle of STREAM, then a fresh short squeeze.
    @(posedge clk); #1;
    rate_blk  = 0;
    start     = 1'b1;
    req_words = LW'(10);
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 50 && cnt < 4; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        check("pre_rst_word", out_data, exp_word(0, cnt));
        cnt++;
      end
    end
    if (cnt < 4) record_fail("pre_rst_words_missing");
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_squeeze(2, 0, 0, 1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
